debounced_button_counter: RTL and testbench
===========================================

Name: debounced_button_counter

Overview:
- Free-running-clock successor to the button-clocked LED counter.
- Two raw active-low push buttons (increment, decrement) are synchronised, debounced and edge-detected. The result drives a WIDTH-bit up/down counter, displayed on LEDs.
- A wrap-or-saturate mode is selectable by parameter.
- Sits directly between the board PMOD button pins and the LED outputs; buttons are never used as clocks.

Parameters:
- WIDTH, 4, counter and LED width in bits (1..16).
- DEBOUNCE_CYCLES, 120000, consecutive stable clk cycles required to accept a button level change (≥2; 10 ms at 12 MHz).
- SATURATE, 0, 0 = count wraps modulo 2^WIDTH; 1 = count clamps at 0 and 2^WIDTH-1.
- REPEAT_DELAY, 6000000, hold time in cycles before the first auto-repeat. Used only with DBC_AUTO_REPEAT_EN.
- REPEAT_PERIOD, 1200000, cycles between subsequent auto-repeats. Used only with DBC_AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- btn_inc_n  input  1  raw increment button, active-low, asynchronous to clk
- btn_dec_n  input  1  raw decrement button, active-low, asynchronous to clk
- led  output  WIDTH  current count value
- wrap  output  1  one-cycle pulse when the count wraps (SATURATE=0) or an event is discarded at a limit (SATURATE=1)

Behaviour:
- Reset (async assert, synchronous release):
  - led=0, wrap=0.
  - Synchroniser flops=1, i.e. released.
  - Debounced levels=released; debounce counters=0; repeat state=IDLE.
- Synchroniser: two flops per button; inputs inverted after synchronisation so that internal pressed=1.
- Debounce, per button, with a stable level register and a counter:
  - If synced level equals the stable level: counter clears to 0.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, the stable level takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the stable level.
- Press event: one-cycle registered pulse on a stable-level 0->1 transition. Releases generate no event.
- Latency: raw pin held low from before edge 0 -> led changes on edge DEBOUNCE_CYCLES+3, exactly.
- Count update, on the edge after an event is registered:
  - inc only: led+1.
  - dec only: led-1.
  - inc and dec in the same cycle: no change, wrap=0.
- Wrap rules (SATURATE=0):
  - 2^WIDTH-1 + 1 -> 0 with wrap=1 for one cycle.
  - 0 - 1 -> 2^WIDTH-1 with wrap=1.
- Saturate rules (SATURATE=1):
  - At max, inc leaves led unchanged and pulses wrap=1.
  - At 0, dec leaves led unchanged and pulses wrap=1.
- Holding a button with the macro off produces exactly one event per press.
- rst mid-debounce or mid-hold: everything returns to reset values immediately. A button still held at release of rst must first be debounced as pressed, then generates one event.

Optional Feature:
- Macro: DBC_AUTO_REPEAT_EN.
- Defined: a per-button repeat FSM with states IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on a press event; the counter loads 0.
  - In DELAY, after REPEAT_DELAY cycles still pressed: -> REPEAT and issue one event.
  - In REPEAT, one event every REPEAT_PERIOD cycles while pressed.
  - Any state -> IDLE on debounced release.
  - Repeat events obey the same simultaneous-cancel and wrap/saturate rules.
- Undefined: the FSM and the repeat counters are absent. The REPEAT_* parameters are accepted and ignored.

Decomposition:
- Package dbc_pkg holds:
  - Repeat FSM state encoding (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2).
  - Pressed/released level constants.
  - A function computing counter width, clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1).
- Sub-module button_debouncer, instantiated twice, contains:
  - Synchroniser, debounce counter and stable level.
  - Press pulse.
  - Optional repeat FSM.
- The top level holds only the count arithmetic and the wrap logic.

Test Plan:
- Bench settings: DEBOUNCE_CYCLES=4, WIDTH=4 unless noted.
- Reset during count: led=4'd9, assert rst mid-cycle -> led=0 and wrap=0 immediately, before the next clk edge.
- Bounce rejection: btn_inc_n low for 3 cycles then high, repeated 5 times -> led stays 0. Then hold low 20 cycles -> led=1 at edge 7 after the final fall; no further change while held.
- Wrap: 15 clean inc presses -> led=15. 16th -> led=0 with wrap=1 for exactly one cycle. Then one dec press -> led=15, wrap=1.
- Saturate (SATURATE=1): dec press at led=0 -> led=0, wrap=1. 20 inc presses -> led=15; the last 5 presses each pulse wrap.
- Simultaneous: both buttons fall on the same cycle with led=5 -> led stays 5, wrap=0. Inc press 10 cycles after dec -> led=4 then 5.
- Auto-repeat (macro defined; REPEAT_DELAY=10, REPEAT_PERIOD=5): hold inc 40 cycles past debounce -> 1 press event, +1 at 10 cycles, then +1 every 5 cycles. Release -> no further changes.

Source files
------------

// File: rtl/dbc_pkg.sv
// dbc_pkg: shared definitions for the debounced button counter.
//   rpt_state_t : auto-repeat FSM state encoding (IDLE, DELAY, REPEAT)
//   LVL_*       : internal button level constants (pressed = 1)
//   cnt_width() : width of a counter that must hold the largest cycle count
package dbc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   localparam logic LVL_PRESSED  = 1'b1;
   localparam logic LVL_RELEASED = 1'b0;

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: one raw active-low button -> one-cycle press event.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   btn_n : raw button, active-low, asynchronous to clk
//   press : registered one-cycle event on each accepted press
// Two-flop synchroniser, then a stable level that only follows the synced
// level after DEBOUNCE_CYCLES consecutive differing cycles. With
// DBC_AUTO_REPEAT_EN defined, a repeat FSM adds events while held.
//
// state  | meaning
// IDLE   | not held, waiting for a press event
// DELAY  | held, timing REPEAT_DELAY before the first repeat
// REPEAT | held, one event every REPEAT_PERIOD cycles
module button_debouncer
   import dbc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int REPEAT_DELAY    = 6000000,
   parameter int REPEAT_PERIOD   = 1200000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          synced;
   logic          stable;
   logic          stable_q;
   logic          rise;
   logic [CW-1:0] db_cnt;

   // Synchroniser resets to released (pin high); inversion gives pressed = 1.
   assign synced = ~sync_q[1];
   assign rise   = (stable == LVL_PRESSED) && (stable_q == LVL_RELEASED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= 2'b11;
         stable   <= LVL_RELEASED;
         stable_q <= LVL_RELEASED;
         db_cnt   <= '0;
      end else begin
         sync_q   <= {sync_q[0], btn_n};
         stable_q <= stable;
         if (synced == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            stable <= synced;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + CNT_ONE;
         end
      end
   end

`ifdef DBC_AUTO_REPEAT_EN
   localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

   rpt_state_t    state;
   logic [CW-1:0] rpt_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rpt_cnt <= '0;
         press   <= 1'b0;
      end else begin
         press <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  state   <= DELAY;
                  rpt_cnt <= '0;
                  press   <= 1'b1;
               end
            end
            DELAY: begin
               if (stable != LVL_PRESSED) begin
                  state <= IDLE;
               end else if (rpt_cnt == RD_LAST) begin
                  state   <= REPEAT;
                  rpt_cnt <= '0;
                  press   <= 1'b1;
               end else begin
                  rpt_cnt <= rpt_cnt + CNT_ONE;
               end
            end
            REPEAT: begin
               if (stable != LVL_PRESSED) begin
                  state <= IDLE;
               end else if (rpt_cnt == RP_LAST) begin
                  rpt_cnt <= '0;
                  press   <= 1'b1;
               end else begin
                  rpt_cnt <= rpt_cnt + CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) press <= 1'b0;
      else     press <= rise;
   end
`endif

endmodule

// File: rtl/debounced_button_counter.sv
// debounced_button_counter: debounced inc/dec buttons drive a WIDTH-bit
// up/down counter shown on LEDs.
//   clk       : system clock
//   rst       : asynchronous active-high reset (released synchronously inside)
//   btn_inc_n : raw increment button, active-low
//   btn_dec_n : raw decrement button, active-low
//   led       : current count
//   wrap      : one-cycle pulse on wrap (SATURATE=0) or discarded event at a
//               limit (SATURATE=1)
// Optional macro DBC_AUTO_REPEAT_EN enables hold-to-repeat in the debouncers.
module debounced_button_counter
   import dbc_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int SATURATE        = 0,
   parameter int REPEAT_DELAY    = 6000000,
   parameter int REPEAT_PERIOD   = 1200000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_inc_n,
   input  logic             btn_dec_n,
   output logic [WIDTH-1:0] led,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] MAXV = '1;

   logic [1:0] rst_sync;
   logic       rst_int;
   logic       inc_ev;
   logic       dec_ev;

   // Assert asynchronously, release on the clock so all flops leave reset together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_sync <= 2'b11;
      else     rst_sync <= {rst_sync[0], 1'b0};
   end
   assign rst_int = rst_sync[1];

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
   ) u_inc (
      .clk   (clk),
      .rst   (rst_int),
      .btn_n (btn_inc_n),
      .press (inc_ev)
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
   ) u_dec (
      .clk   (clk),
      .rst   (rst_int),
      .btn_n (btn_dec_n),
      .press (dec_ev)
   );

   // Simultaneous inc and dec cancel with no wrap pulse.
   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         led  <= '0;
         wrap <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (inc_ev && !dec_ev) begin
            if (led == MAXV) begin
               wrap <= 1'b1;
               if (SATURATE == 0) led <= '0;
            end else begin
               led <= led + ONE;
            end
         end else if (dec_ev && !inc_ev) begin
            if (led == '0) begin
               wrap <= 1'b1;
               if (SATURATE == 0) led <= MAXV;
            end else begin
               led <= led - ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_debounced_button_counter.sv
`timescale 1ns/1ps
module tb_debounced_button_counter;

   localparam int WIDTH = 4;
   localparam int DB    = 4;
   localparam int RD    = 10;
   localparam int RP    = 5;
   localparam int MAXV  = 15;
   localparam int OP_INC  = 0;
   localparam int OP_DEC  = 1;
   localparam int OP_BOTH = 2;
`ifdef DBC_AUTO_REPEAT_EN
   localparam int HOLD = 10;
`else
   localparam int HOLD = 20;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             btn_inc_n = 1'b1;
   logic             btn_dec_n = 1'b1;
   logic [WIDTH-1:0] led_w, led_s;
   logic             wrap_w, wrap_s;

   int n_checks = 0;
   int n_pass   = 0;
   int nwrap_w  = 0;
   int nwrap_s  = 0;
   int model_w  = 0;
   int model_s  = 0;

   typedef struct {
      int op;
      int hold;
      int exp_w;
      int exp_s;
      int ww;
      int ws;
   } vec_t;
   vec_t tbl[12];

   always #5 clk = ~clk;

   debounced_button_counter #(
      .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .SATURATE(0),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut_w (
      .clk(clk), .rst(rst), .btn_inc_n(btn_inc_n), .btn_dec_n(btn_dec_n),
      .led(led_w), .wrap(wrap_w)
   );

   debounced_button_counter #(
      .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .SATURATE(1),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut_s (
      .clk(clk), .rst(rst), .btn_inc_n(btn_inc_n), .btn_dec_n(btn_dec_n),
      .led(led_s), .wrap(wrap_s)
   );

   // Number of cycles each wrap output was high.
   always @(negedge clk) begin
      if (!rst) begin
         if (wrap_w) nwrap_w++;
         if (wrap_s) nwrap_s++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      repeat (4) cyc();
      model_w = 0;
      model_s = 0;
   endtask

   task automatic press(input int op, input int hold, input int gap);
      btn_inc_n = (op == OP_DEC);
      btn_dec_n = (op == OP_INC);
      repeat (hold) cyc();
      btn_inc_n = 1'b1;
      btn_dec_n = 1'b1;
      repeat (gap) cyc();
   endtask

   // Reference: a press held at least DB cycles is one event; both cancel.
   task automatic apply_model(input int op, input int hold, output int ww, output int ws);
      int d, raw;
      d = 0;
      if (hold >= DB) d = (op == OP_INC) ? 1 : (op == OP_DEC) ? -1 : 0;
      raw = model_w + d;
      ww = (raw < 0 || raw > MAXV) ? 1 : 0;
      model_w = (raw + MAXV + 1) % (MAXV + 1);
      raw = model_s + d;
      ws = (raw < 0 || raw > MAXV) ? 1 : 0;
      model_s = (raw < 0) ? 0 : (raw > MAXV) ? MAXV : raw;
   endtask

   task automatic trial(input string tag, input int op, input int hold, input int gap);
      int w0, s0, ew, es;
      w0 = nwrap_w;
      s0 = nwrap_s;
      press(op, hold, gap);
      apply_model(op, hold, ew, es);
      check($sformatf("%s led_w", tag), int'(led_w), model_w);
      check($sformatf("%s led_s", tag), int'(led_s), model_s);
      check($sformatf("%s wrap_w", tag), nwrap_w - w0, ew);
      check($sformatf("%s wrap_s", tag), nwrap_s - s0, es);
   endtask

`ifdef DBC_AUTO_REPEAT_EN
   // Raw pin low from edge 0 through edge REL_EDGE-1.
   localparam int REL_EDGE = 44;
   function automatic int rep_expect(input int e);
      int n;
      n = (e >= DB + 3) ? 1 : 0;
      for (int u = DB + 3 + RD; u <= REL_EDGE + DB + 2; u += RP)
         if (e >= u) n++;
      return n;
   endfunction
`endif

   initial begin
      int w0, s0, op, hold, gap;

      tbl[0]  = '{OP_DEC,  6, 0,  0, 0, 0};
      tbl[1]  = '{OP_DEC,  6, 15, 0, 1, 1};
      tbl[2]  = '{OP_INC,  6, 0,  1, 1, 0};
      tbl[3]  = '{OP_BOTH, 6, 0,  1, 0, 0};
      tbl[4]  = '{OP_INC,  3, 0,  1, 0, 0};
      tbl[5]  = '{OP_INC,  4, 1,  2, 0, 0};
      tbl[6]  = '{OP_INC,  7, 2,  3, 0, 0};
      tbl[7]  = '{OP_INC,  7, 3,  4, 0, 0};
      tbl[8]  = '{OP_INC,  5, 4,  5, 0, 0};
      tbl[9]  = '{OP_INC,  9, 5,  6, 0, 0};
      tbl[10] = '{OP_BOTH, 8, 5,  6, 0, 0};
      tbl[11] = '{OP_DEC,  3, 5,  6, 0, 0};

      // Reset state
      repeat (3) cyc();
      check("reset led_w", int'(led_w), 0);
      check("reset led_s", int'(led_s), 0);
      check("reset wrap_w", int'(wrap_w), 0);
      check("reset wrap_s", int'(wrap_s), 0);
      rst = 1'b0;
      repeat (4) cyc();

      // Bounce rejection then exact latency
      repeat (5) press(OP_INC, 3, 3);
      check("bounce led_w", int'(led_w), 0);
      check("bounce led_s", int'(led_s), 0);
      btn_inc_n = 1'b0;
      repeat (7) cyc();
      check("latency edge6 led_w", int'(led_w), 0);
      cyc();
      check("latency edge7 led_w", int'(led_w), 1);
      check("latency edge7 led_s", int'(led_s), 1);
      repeat (HOLD - 8) cyc();
      check("held led_w", int'(led_w), 1);
      btn_inc_n = 1'b1;
      repeat (12) cyc();
      check("released led_w", int'(led_w), 1);
      model_w = 1;
      model_s = 1;

      // Table of single presses
      for (int i = 0; i < 12; i++) begin
         w0 = nwrap_w;
         s0 = nwrap_s;
         press(tbl[i].op, tbl[i].hold, 10);
         check($sformatf("tbl%0d led_w", i), int'(led_w), tbl[i].exp_w);
         check($sformatf("tbl%0d led_s", i), int'(led_s), tbl[i].exp_s);
         check($sformatf("tbl%0d wrap_w", i), nwrap_w - w0, tbl[i].ww);
         check($sformatf("tbl%0d wrap_s", i), nwrap_s - s0, tbl[i].ws);
      end

      // Dec, then inc falling 10 cycles later
      w0 = nwrap_w;
      btn_dec_n = 1'b0;
      repeat (9) cyc();
      check("stagger mid led_w", int'(led_w), 4);
      check("stagger mid led_s", int'(led_s), 5);
      cyc();
      btn_dec_n = 1'b1;
      btn_inc_n = 1'b0;
      repeat (HOLD) cyc();
      btn_inc_n = 1'b1;
      repeat (12) cyc();
      check("stagger end led_w", int'(led_w), 5);
      check("stagger end led_s", int'(led_s), 6);
      check("stagger wrap_w", nwrap_w - w0, 0);
      model_w = 5;
      model_s = 6;

      // Count to 9, then reset mid-cycle while a press is debouncing
      for (int i = 0; i < 4; i++) trial($sformatf("to9_%0d", i), OP_INC, 6, 8);
      check("pre-reset led_w", int'(led_w), 9);
      btn_inc_n = 1'b0;
      cyc();
      cyc();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async reset led_w", int'(led_w), 0);
      check("async reset led_s", int'(led_s), 0);
      check("async reset wrap_w", int'(wrap_w), 0);
      check("async reset wrap_s", int'(wrap_s), 0);
      cyc();
      cyc();
      rst = 1'b0;
      w0 = nwrap_w;
      repeat (HOLD) cyc();
      btn_inc_n = 1'b1;
      repeat (12) cyc();
      check("held-through-reset led_w", int'(led_w), 1);
      check("held-through-reset led_s", int'(led_s), 1);
      check("held-through-reset wrap_w", nwrap_w - w0, 0);

      // Wrap and saturate over 20 increments, then one decrement
      do_reset();
      w0 = nwrap_w;
      s0 = nwrap_s;
      for (int i = 1; i <= 20; i++) begin
         trial($sformatf("inc%0d", i), OP_INC, 6, 8);
         if (i == 15) begin
            check("inc15 led_w", int'(led_w), 15);
            check("inc15 led_s", int'(led_s), 15);
         end
         if (i == 16) begin
            check("inc16 led_w", int'(led_w), 0);
            check("inc16 wrapcycles_w", nwrap_w - w0, 1);
         end
      end
      check("inc20 led_s", int'(led_s), 15);
      check("inc20 total wrap_s", nwrap_s - s0, 5);
      check("inc20 total wrap_w", nwrap_w - w0, 1);
      trial("dec_after", OP_DEC, 6, 8);

      // Randomised presses, glitches and simultaneous presses
      for (int i = 0; i < 40; i++) begin
         op   = int'($urandom_range(0, 2));
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DB - 1))
                                            : int'($urandom_range(DB, 9));
         gap  = int'($urandom_range(8, 12));
         trial($sformatf("rnd%0d", i), op, hold, gap);
      end

`ifdef DBC_AUTO_REPEAT_EN
      do_reset();
      w0 = nwrap_w;
      btn_inc_n = 1'b0;
      for (int e = 0; e < 60; e++) begin
         cyc();
         check($sformatf("repeat e%0d led_w", e), int'(led_w), rep_expect(e));
         check($sformatf("repeat e%0d led_s", e), int'(led_s), rep_expect(e));
         if (e == REL_EDGE - 1) btn_inc_n = 1'b1;
      end
      check("repeat wrap_w", nwrap_w - w0, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
